// File: rtl/mem_access_stage.sv
// MEM pipeline stage: performs data-memory loads/stores over a req/ack handshake,
// stalls upstream while an access is outstanding and produces the MEM_WB register.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_MEM_valid,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_regwrite,
    input  logic        EX_MEM_memread,
    input  logic        EX_MEM_memwrite,
    input  logic [2:0]  EX_MEM_funct3,
    input  logic [31:0] EX_MEM_ALU_result,
    input  logic [31:0] EX_MEM_rs2_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        MEM_stall,
    output logic        MEM_WB_valid,
    output logic [4:0]  MEM_WB_rd,
    output logic [31:0] MEM_WB_result,
    output logic        MEM_WB_regwrite,
    output logic        MEM_misaligned,
    output logic        MEM_bus_error,
    output logic        dbg_state_o
);

    // Handshake: dmem_req is high for the whole BUSY state with addr/we/wdata/wstrb
    // stable (EX_MEM is frozen by MEM_stall); the single cycle with dmem_ack=1
    // completes the access. dmem_ack outside BUSY is ignored.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic                     TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE      = TIMEOUT_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     wb_valid_q, wb_valid_d;
    logic [4:0]               wb_rd_q, wb_rd_d;
    logic [31:0]              wb_result_q, wb_result_d;
    logic                     wb_regwrite_q, wb_regwrite_d;
    logic                     misaligned_q, misaligned_d;
    logic                     bus_error_q, bus_error_d;

    logic        is_load, is_store, mem_op, misaligned, wb_we;
    logic [1:0]  byte_off, size;
    logic [31:0] lane, load_data;
    logic        stall;

    assign is_load  = EX_MEM_memread;
    assign is_store = ~EX_MEM_memread & EX_MEM_memwrite;
    assign mem_op   = EX_MEM_valid & (EX_MEM_memread | EX_MEM_memwrite);
    assign byte_off = EX_MEM_ALU_result[1:0];
    assign size     = EX_MEM_funct3[1:0];
    assign wb_we    = EX_MEM_regwrite & (EX_MEM_rd != 5'd0) & ~is_store;

    always_comb begin
        misaligned = 1'b0;
        case (EX_MEM_funct3)
            3'b011, 3'b110, 3'b111: misaligned = 1'b1;
            3'b001, 3'b101:         misaligned = byte_off[0];
            3'b010:                 misaligned = (byte_off != 2'b00);
            default:                misaligned = 1'b0;
        endcase
    end

    // Right-align the addressed lane, then extend according to funct3.
    assign lane = dmem_rdata >> {byte_off, 3'b000};

    always_comb begin
        load_data = dmem_rdata;
        case (EX_MEM_funct3)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_data = {24'd0, lane[7:0]};
            3'b101:  load_data = {16'd0, lane[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_result_d   = wb_result_q;
        wb_regwrite_d = 1'b0;
        misaligned_d  = 1'b0;
        bus_error_d   = 1'b0;
        stall         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        misaligned_d = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = S_BUSY;
                        cnt_d   = '0;
                    end
                end else if (EX_MEM_valid) begin
                    wb_valid_d    = 1'b1;
                    wb_rd_d       = EX_MEM_rd;
                    wb_result_d   = EX_MEM_ALU_result;
                    wb_regwrite_d = wb_we;
                end
            end
            S_BUSY: begin
                if (dmem_ack) begin
                    wb_valid_d    = 1'b1;
                    wb_rd_d       = EX_MEM_rd;
                    wb_result_d   = is_load ? load_data : EX_MEM_ALU_result;
                    wb_regwrite_d = wb_we;
                    state_d       = S_IDLE;
                    cnt_d         = '0;
                end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
                    bus_error_d = 1'b1;
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_result_q   <= 32'd0;
            wb_regwrite_q <= 1'b0;
            misaligned_q  <= 1'b0;
            bus_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_result_q   <= wb_result_d;
            wb_regwrite_q <= wb_regwrite_d;
            misaligned_q  <= misaligned_d;
            bus_error_q   <= bus_error_d;
        end
    end

    // Request is a pure function of state so an asynchronous reset drops it at once.
    assign dmem_req  = (state_q == S_BUSY);
    assign dmem_we   = dmem_req & is_store;
    assign dmem_addr = {EX_MEM_ALU_result[31:2], 2'b00};

    always_comb begin
        dmem_wstrb = 4'b0000;
        dmem_wdata = EX_MEM_rs2_data;
        case (size)
            2'b00:   dmem_wdata = {4{EX_MEM_rs2_data[7:0]}};
            2'b01:   dmem_wdata = {2{EX_MEM_rs2_data[15:0]}};
            default: dmem_wdata = EX_MEM_rs2_data;
        endcase
        if (dmem_we) begin
            case (size)
                2'b00:   dmem_wstrb = 4'b0001 << byte_off;
                2'b01:   dmem_wstrb = 4'b0011 << byte_off;
                default: dmem_wstrb = 4'b1111;
            endcase
        end
    end

    assign MEM_stall       = stall;
    assign MEM_WB_valid    = wb_valid_q;
    assign MEM_WB_rd       = wb_rd_q;
    assign MEM_WB_result   = wb_result_q;
    assign MEM_WB_regwrite = wb_regwrite_q;
    assign MEM_misaligned  = misaligned_q;
    assign MEM_bus_error   = bus_error_q;
    assign dbg_state_o     = (state_q == S_BUSY);

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: each instruction's outcome is predicted
// from the access rules (size, lane, extension, timeout) and compared cycle by cycle.
module tb_mem_access_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        EX_MEM_valid;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_regwrite;
    logic        EX_MEM_memread;
    logic        EX_MEM_memwrite;
    logic [2:0]  EX_MEM_funct3;
    logic [31:0] EX_MEM_ALU_result;
    logic [31:0] EX_MEM_rs2_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        MEM_stall;
    logic        MEM_WB_valid;
    logic [4:0]  MEM_WB_rd;
    logic [31:0] MEM_WB_result;
    logic        MEM_WB_regwrite;
    logic        MEM_misaligned;
    logic        MEM_bus_error;
    logic        dbg_state_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference copy of the held MEM_WB rd/result.
    logic [4:0]  exp_rd;
    logic [31:0] exp_result;

    mem_access_stage #(
        .TIMEOUT_CYCLES(TMO),
        .TIMEOUT_WIDTH (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .EX_MEM_valid     (EX_MEM_valid),
        .EX_MEM_rd        (EX_MEM_rd),
        .EX_MEM_regwrite  (EX_MEM_regwrite),
        .EX_MEM_memread   (EX_MEM_memread),
        .EX_MEM_memwrite  (EX_MEM_memwrite),
        .EX_MEM_funct3    (EX_MEM_funct3),
        .EX_MEM_ALU_result(EX_MEM_ALU_result),
        .EX_MEM_rs2_data  (EX_MEM_rs2_data),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .MEM_stall        (MEM_stall),
        .MEM_WB_valid     (MEM_WB_valid),
        .MEM_WB_rd        (MEM_WB_rd),
        .MEM_WB_result    (MEM_WB_result),
        .MEM_WB_regwrite  (MEM_WB_regwrite),
        .MEM_misaligned   (MEM_misaligned),
        .MEM_bus_error    (MEM_bus_error),
        .dbg_state_o      (dbg_state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
        int     nbytes;
        longint span;
        longint v;
        nbytes = 1 << int'(f3[1:0]);
        span   = longint'(1) << (8 * nbytes);
        v      = {32'd0, word};
        v      = (v >> (8 * int'(addr[1:0]))) % span;
        if (!f3[2] && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int nbytes);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nbytes) +: 8];
        return r;
    endfunction

    // One instruction through the stage, followed by one bubble cycle.
    // ack_k: BUSY cycle (1-based) in which dmem_ack is pulsed; 0 means never.
    task automatic do_op(input logic v, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int ack_k, input logic idle_ack);
        logic mem_op, is_load, is_store, misal, acked;
        int   nbytes, last, stalls;
        logic [31:0] strb;

        @(posedge clk); #1;
        check("bubble_valid", MEM_WB_valid, 1'b0);
        check("bubble_regwrite", MEM_WB_regwrite, 1'b0);
        check("bubble_rd_held", MEM_WB_rd, exp_rd);
        check("bubble_result_held", MEM_WB_result, exp_result);
        check("misaligned_idle", MEM_misaligned, 1'b0);
        check("bus_error_idle", MEM_bus_error, 1'b0);

        EX_MEM_valid      = v;
        EX_MEM_rd         = rd;
        EX_MEM_regwrite   = rw;
        EX_MEM_memread    = mr;
        EX_MEM_memwrite   = mw;
        EX_MEM_funct3     = f3;
        EX_MEM_ALU_result = alu;
        EX_MEM_rs2_data   = rs2;
        dmem_ack          = idle_ack;
        dmem_rdata        = $urandom;

        mem_op   = v && (mr || mw);
        is_load  = mr;
        is_store = !mr && mw;
        nbytes   = 1 << int'(f3[1:0]);
        misal    = mem_op && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 ||
                              (int'(alu[2:0]) % nbytes) != 0);
        acked    = (ack_k >= 1 && ack_k <= TMO);
        strb     = ((32'd1 << nbytes) - 32'd1) << alu[1:0];

        @(negedge clk);
        check("idle_stall", MEM_stall, mem_op && !misal);
        check("idle_req", dmem_req, 1'b0);
        check("idle_state", dbg_state_o, 1'b0);

        if (mem_op && !misal) begin
            stalls = 1;
            last   = acked ? ack_k : TMO;
            for (int n = 1; n <= last; n++) begin
                @(posedge clk); #1;
                dmem_ack   = (n == ack_k);
                dmem_rdata = (n == ack_k) ? rdata : $urandom;
                @(negedge clk);
                check("busy_req", dmem_req, 1'b1);
                check("busy_state", dbg_state_o, 1'b1);
                check("busy_addr", dmem_addr, alu & 32'hFFFF_FFFC);
                check("busy_we", dmem_we, is_store);
                check("busy_wstrb", dmem_wstrb, is_store ? strb[3:0] : 4'b0000);
                if (is_store) check("busy_wdata", dmem_wdata, ref_wdata(rs2, nbytes));
                stalls += int'(MEM_stall);
            end
            check("stall_cycles", stalls, acked ? ack_k : TMO);
        end

        @(posedge clk); #1;
        if (!v || misal || (mem_op && !acked)) begin
            check("wb_valid", MEM_WB_valid, 1'b0);
            check("wb_regwrite", MEM_WB_regwrite, 1'b0);
        end else begin
            exp_rd     = rd;
            exp_result = (mem_op && is_load) ? ref_load(rdata, alu, f3) : alu;
            check("wb_valid", MEM_WB_valid, 1'b1);
            check("wb_regwrite", MEM_WB_regwrite, rw && rd != 5'd0 && !(mem_op && is_store));
        end
        check("wb_rd", MEM_WB_rd, exp_rd);
        check("wb_result", MEM_WB_result, exp_result);
        check("misaligned_pulse", MEM_misaligned, misal);
        check("bus_error_pulse", MEM_bus_error, mem_op && !misal && !acked);

        EX_MEM_valid    = 1'b0;
        EX_MEM_memread  = 1'($urandom_range(0, 1));
        EX_MEM_memwrite = 1'($urandom_range(0, 1));
        dmem_ack        = 1'($urandom_range(0, 1));
        dmem_rdata      = $urandom;
        @(negedge clk);
        check("bubble_req", dmem_req, 1'b0);
        check("bubble_stall", MEM_stall, 1'b0);
    endtask

    task automatic reset_mid_access();
        @(posedge clk); #1;
        EX_MEM_valid      = 1'b1;
        EX_MEM_rd         = 5'd9;
        EX_MEM_regwrite   = 1'b1;
        EX_MEM_memread    = 1'b1;
        EX_MEM_memwrite   = 1'b0;
        EX_MEM_funct3     = 3'b010;
        EX_MEM_ALU_result = 32'h0000_0040;
        dmem_ack          = 1'b0;
        @(negedge clk);
        check("rst_test_accept_stall", MEM_stall, 1'b1);
        repeat (2) begin
            @(posedge clk); #1;
            dmem_ack = 1'b0;
        end
        @(negedge clk);
        check("rst_test_req_before", dmem_req, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_async_req", dmem_req, 1'b0);
        check("rst_async_valid", MEM_WB_valid, 1'b0);
        check("rst_async_rd", MEM_WB_rd, 5'd0);
        check("rst_async_result", MEM_WB_result, 32'd0);
        check("rst_async_regwrite", MEM_WB_regwrite, 1'b0);
        exp_rd     = 5'd0;
        exp_result = 32'd0;
        @(posedge clk); #1;
        rst          = 1'b0;
        EX_MEM_valid = 1'b0;
        dmem_ack     = 1'b1;
        dmem_rdata   = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check("stray_ack_valid", MEM_WB_valid, 1'b0);
        check("stray_ack_regwrite", MEM_WB_regwrite, 1'b0);
        check("stray_ack_result", MEM_WB_result, 32'd0);
        check("stray_ack_state", dbg_state_o, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  bad_f3[3] = '{3'b011, 3'b110, 3'b111};

    initial begin
        logic        r_v, r_mr, r_mw, r_rw;
        logic [4:0]  r_rd;
        logic [2:0]  r_f3;
        logic [31:0] r_alu;
        int          kind, r_ack, r_bytes;

        rst               = 1'b1;
        EX_MEM_valid      = 1'b0;
        EX_MEM_rd         = 5'd0;
        EX_MEM_regwrite   = 1'b0;
        EX_MEM_memread    = 1'b0;
        EX_MEM_memwrite   = 1'b0;
        EX_MEM_funct3     = 3'b000;
        EX_MEM_ALU_result = 32'd0;
        EX_MEM_rs2_data   = 32'd0;
        dmem_ack          = 1'b0;
        dmem_rdata        = 32'd0;
        exp_rd            = 5'd0;
        exp_result        = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req", dmem_req, 1'b0);
        check("reset_stall", MEM_stall, 1'b0);
        check("reset_wb_valid", MEM_WB_valid, 1'b0);
        check("reset_wb_rd", MEM_WB_rd, 5'd0);
        check("reset_wb_result", MEM_WB_result, 32'd0);
        check("reset_wb_regwrite", MEM_WB_regwrite, 1'b0);
        check("reset_misaligned", MEM_misaligned, 1'b0);
        check("reset_bus_error", MEM_bus_error, 1'b0);
        check("reset_state", dbg_state_o, 1'b0);
        rst = 1'b0;

        // ALU op, LB with late ack, SH, misaligned LW, timeout then ALU op.
        do_op(1, 5'd5, 1, 0, 0, 3'b000, 32'h0000_1234, 32'd0, 32'd0, 0, 0);
        do_op(1, 5'd7, 1, 1, 0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_0000, 4, 0);
        do_op(1, 5'd3, 1, 0, 1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'd0, 1, 0);
        do_op(1, 5'd4, 1, 1, 0, 3'b010, 32'h0000_0006, 32'd0, 32'd0, 1, 0);
        do_op(1, 5'd6, 1, 1, 0, 3'b010, 32'h0000_0010, 32'd0, 32'd0, 0, 0);
        do_op(1, 5'd8, 1, 0, 0, 3'b000, 32'hCAFE_0001, 32'd0, 32'd0, 0, 1);
        do_op(1, 5'd0, 1, 1, 0, 3'b100, 32'h0000_0021, 32'd0, 32'h1234_8856, 1, 1);
        reset_mid_access();

        for (int t = 0; t < 400; t++) begin
            r_v  = ($urandom_range(0, 9) != 0);
            kind = $urandom_range(0, 3);
            r_mr = (kind == 1 || kind == 3);
            r_mw = (kind == 2 || kind == 3);
            r_rw = 1'($urandom_range(0, 3) != 0);
            r_rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if ($urandom_range(0, 7) == 0) r_f3 = bad_f3[$urandom_range(0, 2)];
            else if (kind == 2)            r_f3 = 3'($urandom_range(0, 2));
            else                           r_f3 = ld_f3[$urandom_range(0, 4)];
            r_bytes = 1 << int'(r_f3[1:0]);
            r_alu   = $urandom;
            if ($urandom_range(0, 2) != 0) r_alu = r_alu & ~32'(r_bytes - 1);
            r_ack = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TMO + 1);
            do_op(r_v, r_rd, r_rw, r_mr, r_mw, r_f3, r_alu, $urandom, $urandom, r_ack,
                  1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
